// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the fetch PC, keeps a single request in flight,
// fills the IF/ID slot and parks one instruction under decode stall, and squashes on redirect.
module fetch_sequencer #(
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    DATA_WIDTH  = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req_valid,
  output logic [DATA_WIDTH-1:0]  imem_req_addr,
  input  logic                   imem_req_ready,
  input  logic                   imem_resp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_resp_data,
  input  logic                   redirect_valid,
  input  logic [DATA_WIDTH-1:0]  redirect_pc,
  input  logic                   id_stall,
  output logic                   ifid_valid,
  output logic [DATA_WIDTH-1:0]  ifid_pc,
  output logic [INSTR_WIDTH-1:0] ifid_instr
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;

  state_t                 state_reg, state_next;
  logic [DATA_WIDTH-1:0]  pc_reg, pc_next;
  logic                   ifid_valid_reg, ifid_valid_next;
  logic [DATA_WIDTH-1:0]  ifid_pc_reg, ifid_pc_next;
  logic [INSTR_WIDTH-1:0] ifid_instr_reg, ifid_instr_next;
  logic                   hold_valid_reg, hold_valid_next;
  logic [DATA_WIDTH-1:0]  hold_pc_reg, hold_pc_next;
  logic [INSTR_WIDTH-1:0] hold_instr_reg, hold_instr_next;

  logic [DATA_WIDTH-1:0]  redirect_target;
  logic [DATA_WIDTH-1:0]  pc_inc;
  logic                   slot_free;

  assign redirect_target = redirect_pc & ~DATA_WIDTH'(3);
  assign pc_inc          = pc_reg + DATA_WIDTH'(4);
  assign slot_free       = !ifid_valid_reg || !id_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC;
      ifid_valid_reg <= 1'b0;
      ifid_pc_reg    <= '0;
      ifid_instr_reg <= '0;
      hold_valid_reg <= 1'b0;
      hold_pc_reg    <= '0;
      hold_instr_reg <= '0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      ifid_valid_reg <= ifid_valid_next;
      ifid_pc_reg    <= ifid_pc_next;
      ifid_instr_reg <= ifid_instr_next;
      hold_valid_reg <= hold_valid_next;
      hold_pc_reg    <= hold_pc_next;
      hold_instr_reg <= hold_instr_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    hold_valid_next = hold_valid_reg;
    hold_pc_next    = hold_pc_reg;
    hold_instr_next = hold_instr_reg;
    // Decode consumes the slot whenever it is not stalled; loads below override this bubble.
    if (id_stall) begin
      ifid_valid_next = ifid_valid_reg;
      ifid_pc_next    = ifid_pc_reg;
      ifid_instr_next = ifid_instr_reg;
    end else begin
      ifid_valid_next = 1'b0;
      ifid_pc_next    = '0;
      ifid_instr_next = '0;
    end

    if (redirect_valid && state_reg != IDLE) begin
      pc_next         = redirect_target;
      ifid_valid_next = 1'b0;
      ifid_pc_next    = '0;
      ifid_instr_next = '0;
      hold_valid_next = 1'b0;
      hold_pc_next    = '0;
      hold_instr_next = '0;
      // A request already accepted (or still pending) must have its response thrown away.
      case (state_reg)
        REQ:     state_next = imem_req_ready ? DROP : REQ;
        WAIT:    state_next = imem_resp_valid ? REQ : DROP;
        HOLD:    state_next = REQ;
        DROP:    state_next = DROP;
        default: state_next = state_reg;
      endcase
    end else begin
      case (state_reg)
        IDLE: state_next = REQ;
        REQ: if (imem_req_ready) state_next = WAIT;
        WAIT: begin
          if (imem_resp_valid) begin
            pc_next = pc_inc;
            if (slot_free) begin
              ifid_valid_next = 1'b1;
              ifid_pc_next    = pc_reg;
              ifid_instr_next = imem_resp_data;
              state_next      = REQ;
            end else begin
              hold_valid_next = 1'b1;
              hold_pc_next    = pc_reg;
              hold_instr_next = imem_resp_data;
              state_next      = HOLD;
            end
          end
        end
        HOLD: begin
          if (!id_stall) begin
            ifid_valid_next = hold_valid_reg;
            ifid_pc_next    = hold_pc_reg;
            ifid_instr_next = hold_instr_reg;
            hold_valid_next = 1'b0;
            hold_pc_next    = '0;
            hold_instr_next = '0;
            state_next      = REQ;
          end
        end
        DROP: if (imem_resp_valid) state_next = REQ;
        default: state_next = IDLE;
      endcase
    end
  end

  assign imem_req_valid = (state_reg == REQ);
  assign imem_req_addr  = pc_reg;
  assign ifid_valid     = ifid_valid_reg;
  assign ifid_pc        = ifid_pc_reg;
  assign ifid_instr     = ifid_instr_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized run checked by an
// in-order instruction-stream scoreboard and a behavioural memory model.
module tb_fetch_sequencer;

  localparam logic [63:0] RPC = 64'h1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        id_stall = 1'b0;
  logic        ifid_valid;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;

  int total = 0;
  int bad = 0;

  fetch_sequencer #(.INSTR_WIDTH(32), .DATA_WIDTH(64), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_stall(id_stall),
    .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed, address-unique pattern.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h9E37_79B9;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%0b want=0", imem_req_valid); end
    total++; if (imem_req_addr !== RPC) begin bad++; $display("FAIL reset_req_addr got=%h want=%h", imem_req_addr, RPC); end
    total++; if (ifid_valid !== 1'b0 || ifid_pc !== 64'h0 || ifid_instr !== 32'h0) begin bad++; $display("FAIL reset_ifid got=%0b/%h/%h want=0/0/0", ifid_valid, ifid_pc, ifid_instr); end
    reset = 1'b1;
    tick();
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin bad++; $display("FAIL first_req got=%0b/%h want=1/%h", imem_req_valid, imem_req_addr, RPC); end
    $display("test_reset done");
  endtask

  task automatic test_free_run();
    logic [63:0] exp_pc = RPC;
    for (int i = 0; i < 3; i++) begin
      total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin bad++; $display("FAIL free_req got=%0b/%h want=1/%h", imem_req_valid, imem_req_addr, exp_pc); end
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      total++; if (imem_req_valid !== 1'b0 || ifid_valid !== 1'b0) begin bad++; $display("FAIL free_wait got=req%0b/ifid%0b want=0/0", imem_req_valid, ifid_valid); end
      imem_resp_valid = 1'b1; imem_resp_data = mem_word(exp_pc);
      tick();
      imem_resp_valid = 1'b0;
      total++; if (ifid_valid !== 1'b1 || ifid_pc !== exp_pc || ifid_instr !== mem_word(exp_pc)) begin bad++; $display("FAIL free_ifid got=%0b/%h/%h want=1/%h/%h", ifid_valid, ifid_pc, ifid_instr, exp_pc, mem_word(exp_pc)); end
      $display("free_run fetch pc=%h valid=%0b", ifid_pc, ifid_valid);
      exp_pc += 64'd4;
    end
  endtask

  task automatic test_backpressure();
    id_stall = 1'b1; imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = mem_word(64'h100C);
    tick();
    imem_resp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++; if (imem_req_valid !== 1'b0 || ifid_valid !== 1'b1 || ifid_pc !== 64'h1008) begin bad++; $display("FAIL bp_hold got=req%0b/%0b/%h want=0/1/1008", imem_req_valid, ifid_valid, ifid_pc); end
      tick();
    end
    id_stall = 1'b0;
    tick();
    total++; if (ifid_valid !== 1'b1 || ifid_pc !== 64'h100C || ifid_instr !== mem_word(64'h100C)) begin bad++; $display("FAIL bp_release got=%0b/%h/%h want=1/100c/%h", ifid_valid, ifid_pc, ifid_instr, mem_word(64'h100C)); end
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h1010) begin bad++; $display("FAIL bp_resume got=%0b/%h want=1/1010", imem_req_valid, imem_req_addr); end
    $display("backpressure released pc=%h next_req=%h", ifid_pc, imem_req_addr);
  endtask

  task automatic test_redirect_wait();
    redirect_valid = 1'b1; redirect_pc = 64'h2000;
    tick();
    redirect_valid = 1'b0;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h2000 || ifid_valid !== 1'b0) begin bad++; $display("FAIL rw_req got=%0b/%h/%0b want=1/2000/0", imem_req_valid, imem_req_addr, ifid_valid); end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h3002;
    tick();
    redirect_valid = 1'b0;
    total++; if (imem_req_valid !== 1'b0 || ifid_valid !== 1'b0) begin bad++; $display("FAIL rw_drop got=%0b/%0b want=0/0", imem_req_valid, ifid_valid); end
    imem_resp_valid = 1'b1; imem_resp_data = mem_word(64'h2000);
    tick();
    imem_resp_valid = 1'b0;
    total++; if (ifid_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h3000) begin bad++; $display("FAIL rw_after got=%0b/%0b/%h want=0/1/3000", ifid_valid, imem_req_valid, imem_req_addr); end
    $display("redirect_wait next_req=%h", imem_req_addr);
  endtask

  task automatic test_redirect_resp();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h4000;
    imem_resp_valid = 1'b1; imem_resp_data = mem_word(64'h3000);
    tick();
    redirect_valid = 1'b0; imem_resp_valid = 1'b0;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h4000 || ifid_valid !== 1'b0) begin bad++; $display("FAIL rr got=%0b/%h/%0b want=1/4000/0", imem_req_valid, imem_req_addr, ifid_valid); end
    $display("redirect_resp next_req=%h", imem_req_addr);
  endtask

  task automatic test_redirect_hold();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = mem_word(64'h4000);
    tick();
    imem_resp_valid = 1'b0;
    id_stall = 1'b1; imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = mem_word(64'h4004);
    tick();
    imem_resp_valid = 1'b0;
    total++; if (imem_req_valid !== 1'b0 || ifid_valid !== 1'b1 || ifid_pc !== 64'h4000) begin bad++; $display("FAIL rh_hold got=%0b/%0b/%h want=0/1/4000", imem_req_valid, ifid_valid, ifid_pc); end
    redirect_valid = 1'b1; redirect_pc = 64'h5000;
    tick();
    redirect_valid = 1'b0;
    total++; if (ifid_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h5000) begin bad++; $display("FAIL rh_redirect got=%0b/%0b/%h want=0/1/5000", ifid_valid, imem_req_valid, imem_req_addr); end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = mem_word(64'h5000);
    tick();
    imem_resp_valid = 1'b0;
    total++; if (ifid_valid !== 1'b1 || ifid_pc !== 64'h5000 || imem_req_addr !== 64'h5004) begin bad++; $display("FAIL rh_reload got=%0b/%h/%h want=1/5000/5004", ifid_valid, ifid_pc, imem_req_addr); end
    id_stall = 1'b0;
    $display("redirect_hold ifid_pc=%h", ifid_pc);
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFD;
    tick();
    redirect_valid = 1'b0;
    total++; if (imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_align got=%h want=fffffffffffffffc", imem_req_addr); end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = mem_word(64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    imem_resp_valid = 1'b0;
    total++; if (ifid_pc !== 64'hFFFF_FFFF_FFFF_FFFC || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin bad++; $display("FAIL wrap got=%h/%0b/%h want=fffffffffffffffc/1/0", ifid_pc, imem_req_valid, imem_req_addr); end
    $display("wrap ifid_pc=%h next_req=%h", ifid_pc, imem_req_addr);
  endtask

  task automatic test_async_reset();
    id_stall = 1'b1; imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    reset = 1'b0;
    #1;
    total++; if (imem_req_valid !== 1'b0 || imem_req_addr !== RPC) begin bad++; $display("FAIL areset_req got=%0b/%h want=0/%h", imem_req_valid, imem_req_addr, RPC); end
    total++; if (ifid_valid !== 1'b0 || ifid_pc !== 64'h0 || ifid_instr !== 32'h0) begin bad++; $display("FAIL areset_ifid got=%0b/%h/%h want=0/0/0", ifid_valid, ifid_pc, ifid_instr); end
    @(negedge clk);
    id_stall = 1'b0; reset = 1'b1;
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
    tick();
    total++; if (ifid_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin bad++; $display("FAIL areset_idle got=%0b/%0b/%h want=0/1/%h", ifid_valid, imem_req_valid, imem_req_addr, RPC); end
    tick();
    imem_resp_valid = 1'b0;
    total++; if (ifid_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin bad++; $display("FAIL areset_req_stale got=%0b/%0b/%h want=0/1/%h", ifid_valid, imem_req_valid, imem_req_addr, RPC); end
    $display("async_reset first_req=%h", imem_req_addr);
  endtask

  // Random traffic: the decode-visible stream must be consecutive words from the last
  // redirect target (or RESET_PC), each carrying that address's memory word.
  task automatic test_random();
    logic        pend = 1'b0;
    logic [63:0] paddr = '0;
    int          cnt = 0;
    logic [63:0] exp_pc = RPC;
    logic        p_redir = 1'b0, p_stall = 1'b0, p_v = 1'b0;
    logic [63:0] p_rpc = '0, p_pc = '0;
    logic [31:0] p_in = '0;
    int          deliv = 0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; redirect_valid = 1'b0; id_stall = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int c = 0; c < 3000; c++) begin
      if (p_redir) begin
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL rnd_squash cyc=%0d got=%0b want=0", c, ifid_valid); end
        exp_pc = p_rpc & ~64'h3;
      end else if (p_v && p_stall) begin
        total++; if (ifid_valid !== 1'b1 || ifid_pc !== p_pc || ifid_instr !== p_in) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%0b/%h/%h want=1/%h/%h", c, ifid_valid, ifid_pc, ifid_instr, p_pc, p_in); end
      end else if (ifid_valid) begin
        total++; if (ifid_pc !== exp_pc || ifid_instr !== mem_word(exp_pc)) begin bad++; $display("FAIL rnd_stream cyc=%0d got=%h/%h want=%h/%h", c, ifid_pc, ifid_instr, exp_pc, mem_word(exp_pc)); end
        $display("rnd deliver cyc=%0d pc=%h instr=%h", c, ifid_pc, ifid_instr);
        exp_pc += 64'd4;
        deliv++;
      end
      if (imem_req_valid) begin
        total++; if (pend) begin bad++; $display("FAIL rnd_outstanding cyc=%0d got=req_while_pending want=no_req", c); end
      end
      imem_resp_valid = 1'b0;
      imem_resp_data = $urandom;
      if (pend) begin
        if (cnt == 0) begin
          imem_resp_valid = 1'b1; imem_resp_data = mem_word(paddr); pend = 1'b0;
        end else cnt--;
      end
      imem_req_ready = ($urandom_range(0, 2) != 0);
      if (imem_req_valid && imem_req_ready) begin
        pend = 1'b1; paddr = imem_req_addr; cnt = $urandom_range(0, 2);
      end
      id_stall = ($urandom_range(0, 2) == 0);
      redirect_valid = !imem_resp_valid && ($urandom_range(0, 15) == 0);
      redirect_pc = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      p_redir = redirect_valid; p_rpc = redirect_pc; p_stall = id_stall;
      p_v = ifid_valid; p_pc = ifid_pc; p_in = ifid_instr;
      tick();
    end
    total++; if (deliv < 100) begin bad++; $display("FAIL rnd_progress got=%0d want>=100", deliv); end
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; redirect_valid = 1'b0; id_stall = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_free_run();
    test_backpressure();
    test_redirect_wait();
    test_redirect_resp();
    test_redirect_hold();
    test_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
